// File: rtl/elink_byte_rx_if.sv
// Byte-wide eLink receive wire plus the assembled-packet handshake towards the emesh side.
// rx_access/rx_wait form a valid/wait pair: a packet moves on any cycle with rx_access=1 and
// rx_wait=0; rxo_wr_wait mirrors that stall back to the link partner.
interface elink_byte_rx_if #(
    parameter int PW = 104
);
    logic          rxi_frame;
    logic [7:0]    rxi_data;
    logic          rxo_wr_wait;
    logic          rx_access;
    logic [PW-1:0] rx_packet;
    logic          rx_wait;

    // Environment side: link partner driving bytes and downstream consumer driving rx_wait.
    modport master (
        output rxi_frame,
        output rxi_data,
        output rx_wait,
        input  rxo_wr_wait,
        input  rx_access,
        input  rx_packet
    );

    // Receiver side.
    modport slave (
        input  rxi_frame,
        input  rxi_data,
        input  rx_wait,
        output rxo_wr_wait,
        output rx_access,
        output rx_packet
    );
endinterface

// File: rtl/elink_byte_rx.sv
// Assembles LSB-first wire bytes into PW-bit emesh packets and hands them downstream through a
// single output register; sticky error flags and a delivered-packet counter for status.
module elink_byte_rx #(
    parameter int  PW = 104,
    localparam int NB = PW / 8,
    localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic          clock,
    input  logic          reset,
    elink_byte_rx_if.slave bus,
    input  logic          clr_status,
    output logic          frame_err,
    output logic          overflow,
    output logic [15:0]   pkt_count,
    output logic [IW:0]   dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic          armed;
    logic [PW-1:0] asm_buf;
    logic          pkt_done;
    logic          acc_q;
    logic [PW-1:0] pkt_q;

    logic xfer;
    logic err_set;
    logic ovf_set;

    assign xfer    = acc_q & ~bus.rx_wait;
    assign err_set = (state == RECV) & ~bus.rxi_frame & (idx != '0);
    assign ovf_set = pkt_done & acc_q & bus.rx_wait;

    assign bus.rx_access   = acc_q;
    assign bus.rx_packet   = pkt_q;
    assign bus.rxo_wr_wait = acc_q & bus.rx_wait;
    assign dbg_state       = {state, idx};

    // Byte assembly FSM. armed stays low after reset until the frame has been seen low, so a
    // frame already in flight at reset release is never picked up half way.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            armed     <= 1'b0;
            asm_buf   <= '0;
            pkt_done  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pkt_done  <= 1'b0;
            frame_err <= err_set | (frame_err & ~clr_status);
            if (!bus.rxi_frame) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.rxi_frame && armed) begin
                        asm_buf[7:0] <= bus.rxi_data;
                        idx          <= IW'(1);
                        state        <= RECV;
                    end
                end
                RECV: begin
                    if (bus.rxi_frame) begin
                        for (int k = 0; k < NB; k++) begin
                            if (idx == IW'(k)) begin
                                asm_buf[8*k +: 8] <= bus.rxi_data;
                            end
                        end
                        if (idx == LAST) begin
                            idx      <= '0;
                            pkt_done <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        idx   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output stage. asm_buf still holds the whole packet in the cycle after pkt_done; only
    // byte 0 of a following packet can land in it on the same edge that copies it out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q     <= 1'b0;
            pkt_q     <= '0;
            overflow  <= 1'b0;
            pkt_count <= 16'd0;
        end else begin
            overflow <= ovf_set | (overflow & ~clr_status);
            if (pkt_done && (!acc_q || xfer)) begin
                acc_q <= 1'b1;
                pkt_q <= asm_buf;
            end else if (xfer) begin
                acc_q <= 1'b0;
            end
            if (xfer) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_elink_byte_rx.sv
// Self-checking bench for elink_byte_rx: vector table, directed corner sequences and a random
// phase, all compared against a packet-level byte-queue model.
module tb_elink_byte_rx;

    localparam int PW = 104;
    localparam int NB = PW / 8;
    localparam int IW = $clog2(NB);

    logic          clock = 1'b0;
    logic          reset;
    logic          clr_status;
    logic          frame_err;
    logic          overflow;
    logic [15:0]   pkt_count;
    logic [IW:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    elink_byte_rx_if #(.PW(PW)) bus ();

    elink_byte_rx #(.PW(PW)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .clr_status (clr_status),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .pkt_count  (pkt_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    bit            m_acc;
    logic [PW-1:0] m_pkt;
    bit            m_err;
    bit            m_ovf;
    logic [15:0]   m_cnt;
    logic [7:0]    m_q[$];
    bit            m_armed;
    bit            m_pend;
    logic [PW-1:0] m_pend_pkt;
    logic [PW-1:0] exp_q[$];

    function automatic void model_reset();
        m_acc   = 1'b0;
        m_pkt   = '0;
        m_err   = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 16'd0;
        m_armed = 1'b0;
        m_pend  = 1'b0;
        m_q.delete();
        exp_q.delete();
    endfunction

    // One clock edge: a packet is a run of NB frame-high bytes, ready one edge after its last
    // byte; it goes out if the output slot is empty or emptying, otherwise it is lost.
    function automatic void model_step(bit f, logic [7:0] d, bit w, bit c);
        bit xfer;
        bit ovf_set;
        bit err_set;
        xfer    = m_acc && !w;
        ovf_set = 1'b0;
        err_set = 1'b0;
        if (xfer) m_cnt = m_cnt + 16'd1;
        if (m_pend) begin
            if (!m_acc || xfer) begin
                m_acc = 1'b1;
                m_pkt = m_pend_pkt;
                exp_q.push_back(m_pend_pkt);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (xfer) begin
            m_acc = 1'b0;
        end
        m_pend = 1'b0;
        if (f) begin
            if (m_armed) begin
                m_q.push_back(d);
                if (m_q.size() == NB) begin
                    for (int k = 0; k < NB; k++) m_pend_pkt[8*k +: 8] = m_q[k];
                    m_pend = 1'b1;
                    m_q.delete();
                end
            end
        end else begin
            if (m_q.size() != 0) err_set = 1'b1;
            m_q.delete();
            m_armed = 1'b1;
        end
        m_err = err_set | (m_err & !c);
        m_ovf = ovf_set | (m_ovf & !c);
    endfunction

    function automatic logic [PW-1:0] pack_seq(input logic [7:0] base);
        logic [PW-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("rx_access", PW'(bus.rx_access), PW'(m_acc));
        chk("rxo_wr_wait", PW'(bus.rxo_wr_wait), PW'(m_acc & bus.rx_wait));
        chk("frame_err", PW'(frame_err), PW'(m_err));
        chk("overflow", PW'(overflow), PW'(m_ovf));
        chk("pkt_count", PW'(pkt_count), PW'(m_cnt));
        if (m_acc) chk("rx_packet", bus.rx_packet, m_pkt);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit f, input logic [7:0] d, input bit w, input bit c);
        bus.rxi_frame = f;
        bus.rxi_data  = d;
        bus.rx_wait   = w;
        clr_status    = c;
        if (bus.rx_access && !w) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver got %h want none at %0t", bus.rx_packet, $time);
            end else begin
                chk("deliver", bus.rx_packet, exp_q.pop_front());
            end
        end
        @(posedge clock);
        model_step(f, d, w, c);
        #1;
        compare_model();
    endtask

    task automatic send_pkt(input logic [7:0] base, input bit w);
        for (int k = 0; k < NB; k++) step(1'b1, base + 8'(k), w, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            bus.rxi_frame = 1'b1;
            bus.rxi_data  = 8'($urandom_range(0, 255));
            @(posedge clock);
            #1;
            compare_model();
        end
        reset = 1'b0;
    endtask

    typedef struct {
        bit            f;
        logic [7:0]    d;
        bit            w;
        bit            c;
        bit            e_acc;
        logic [15:0]   e_cnt;
        logic [PW-1:0] e_pkt;
    } vec_t;

    vec_t          tbl[16];
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic [15:0]   base_cnt;
    int            first_hi;
    int            second_hi;
    int            hi_cnt;

    initial begin
        reset         = 1'b1;
        clr_status    = 1'b0;
        bus.rxi_frame = 1'b0;
        bus.rxi_data  = 8'h00;
        bus.rx_wait   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_access", PW'(bus.rx_access), '0);
        chk("reset_packet", bus.rx_packet, '0);
        chk("reset_count", PW'(pkt_count), '0);
        chk("reset_wr_wait", PW'(bus.rxo_wr_wait), '0);
        chk("reset_dbg", PW'(dbg_state), '0);
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Single packet 0x00..0x0C, no backpressure.
        for (int i = 0; i < 16; i++) begin
            tbl[i].f     = (i < NB);
            tbl[i].d     = (i < NB) ? 8'(i) : 8'h00;
            tbl[i].w     = 1'b0;
            tbl[i].c     = 1'b0;
            tbl[i].e_acc = (i == NB);
            tbl[i].e_cnt = (i > NB) ? 16'd1 : 16'd0;
            tbl[i].e_pkt = 104'h0C0B0A09080706050403020100;
        end
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].f, tbl[i].d, tbl[i].w, tbl[i].c);
            chk("tbl_access", PW'(bus.rx_access), PW'(tbl[i].e_acc));
            chk("tbl_count", PW'(pkt_count), PW'(tbl[i].e_cnt));
            if (tbl[i].e_acc) chk("tbl_packet", bus.rx_packet, tbl[i].e_pkt);
        end

        // Back-to-back: 26 frame-high bytes, two one-cycle pulses 13 apart.
        base_cnt  = m_cnt;
        first_hi  = -1;
        second_hi = -1;
        hi_cnt    = 0;
        for (int i = 0; i < 2 * NB + 4; i++) begin
            if (i < 2 * NB) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
            else            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (bus.rx_access) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
                else              second_hi = i;
            end
        end
        chk("b2b_pulses", PW'(hi_cnt), PW'(2));
        chk("b2b_spacing", PW'(second_hi - first_hi), PW'(NB));
        chk("b2b_count", PW'(pkt_count), PW'(base_cnt + 16'd2));
        chk("b2b_frame_err", PW'(frame_err), '0);

        // Frame dropped after byte 5, then a good packet, then clear.
        for (int k = 0; k < 6; k++) step(1'b1, 8'h50 + 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("abort_err", PW'(frame_err), PW'(1));
        chk("abort_access", PW'(bus.rx_access), '0);
        send_pkt(8'h60, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("after_abort_pkt", bus.rx_packet, pack_seq(8'h60));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_err", PW'(frame_err), '0);

        // Clear coinciding with a new abort: the set wins.
        for (int k = 0; k < 3; k++) step(1'b1, 8'h70 + 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_vs_set", PW'(frame_err), PW'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // rx_wait held across two packets: A held, B dropped.
        base_cnt = m_cnt;
        pa = pack_seq(8'h10);
        send_pkt(8'h10, 1'b1);
        for (int k = 0; k < NB; k++) begin
            step(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0);
            if (k == 6) chk("hold_wr_wait", PW'(bus.rxo_wr_wait), PW'(1));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hold_overflow", PW'(overflow), PW'(1));
        chk("hold_packet_a", bus.rx_packet, pa);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_count", PW'(pkt_count), PW'(base_cnt + 16'd1));
        chk("hold_access", PW'(bus.rx_access), '0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // B completes in the cycle A transfers.
        base_cnt = m_cnt;
        pb = pack_seq(8'h90);
        send_pkt(8'h80, 1'b1);
        send_pkt(8'h90, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("same_cycle_access", PW'(bus.rx_access), PW'(1));
        chk("same_cycle_pkt_b", bus.rx_packet, pb);
        chk("same_cycle_ovf", PW'(overflow), '0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("same_cycle_count", PW'(pkt_count), PW'(base_cnt + 16'd2));

        // Reset at byte 7 with the frame still high across release.
        for (int k = 0; k < 7; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
        do_reset(2);
        for (int k = 0; k < 4; k++) step(1'b1, 8'hE0 + 8'(k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_no_err", PW'(frame_err), '0);
        send_pkt(8'hB0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_pkt", bus.rx_packet, pack_seq(8'hB0));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_count", PW'(pkt_count), PW'(1));

        // Counter wrap.
        force dut.pkt_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.pkt_count;
        send_pkt(8'hC0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_count", PW'(pkt_count), '0);

        // Random phase.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                step(($urandom_range(0, 29) != 0), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 99) < 35), ($urandom_range(0, 19) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elink_byte_rx.md
ELINK_BYTE_RX -- requirements
Module: elink_byte_rx

Interface
REQ-001 Parameter PW, default 104: emesh packet width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NB, default PW/8 (13): bytes per packet on the wire; derived, not overridden.
REQ-003 Port clock, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port rxi_frame, input, 1: high while wire bytes are valid.
REQ-006 Port rxi_data, input, 8: wire byte, sampled when rxi_frame=1.
REQ-007 Port rxo_wr_wait, output, 1: backpressure to the link partner.
REQ-008 Port rx_access, output, 1: rx_packet valid.
REQ-009 Port rx_packet, output, PW: assembled emesh packet.
REQ-010 Port rx_wait, input, 1: downstream not ready.
REQ-011 Port clr_status, input, 1: one-cycle pulse that clears the sticky flags.
REQ-012 Port frame_err, output, 1: sticky, partial packet aborted.
REQ-013 Port overflow, output, 1: sticky, completed packet dropped.
REQ-014 Port pkt_count, output, 16: count of packets delivered downstream.

Function
REQ-015 Wire order SHALL be LSB byte first: byte k carries packet[8k+7:8k], k=0..NB-1.
REQ-016 The FSM SHALL have two states, IDLE and RECV, and a byte index idx of ceil(log2(NB)) bits.
REQ-017 IDLE, rxi_frame=1: capture byte 0, set idx=1, go to RECV.
REQ-018 IDLE, rxi_frame=0: stay in IDLE.
REQ-019 RECV, rxi_frame=1, idx<NB-1: capture byte idx, increment idx.
REQ-020 RECV, rxi_frame=1, idx=NB-1: capture the last byte, mark the packet complete, set idx=0, stay in RECV for back-to-back packets.
REQ-021 RECV, rxi_frame=0, idx=0: go to IDLE with no error.
REQ-022 RECV, rxi_frame=0, idx in 1..NB-1: discard the partial packet, set frame_err=1, set idx=0, go to IDLE.
REQ-023 Latency: rx_access SHALL assert on the clock edge after the edge that samples the last byte.
REQ-024 rx_packet SHALL be registered and stable while rx_access=1 and rx_wait=1.
REQ-025 Transfer occurs on a cycle with rx_access=1 and rx_wait=0.
REQ-026 After a transfer, rx_access SHALL deassert next cycle unless a new packet completes in the transfer cycle.
REQ-027 A packet completing in a transfer cycle SHALL load the output register, keep rx_access=1 and not be dropped.
REQ-028 A packet completing while rx_access=1 and rx_wait=1 SHALL be dropped, leave the output register unchanged and set overflow=1.
REQ-029 rxo_wr_wait SHALL equal rx_access AND rx_wait (combinational).
REQ-030 The block SHALL keep receiving while rxo_wr_wait=1; honouring the wait is the partner's responsibility.
REQ-031 pkt_count SHALL increment by 1 per transfer and wrap 0xFFFF -> 0x0000.
REQ-032 clr_status=1 SHALL clear frame_err and overflow next edge.
REQ-033 If clr_status coincides with a new error event, the set SHALL win.
REQ-034 clr_status SHALL NOT affect pkt_count.

Reset
REQ-035 On reset: FSM=IDLE, idx=0, rx_access=0, rx_packet=0, frame_err=0, overflow=0, pkt_count=0, and therefore rxo_wr_wait=0.
REQ-036 Reset asserted mid-packet SHALL discard the partial packet without setting frame_err.
REQ-037 After reset release, a packet SHALL be accepted only from a fresh frame rise in IDLE.
REQ-038 Input frame and bytes present during reset SHALL be ignored.

Verification
REQ-039 Single packet, rx_wait=0, wire bytes 0x00..0x0C -> rx_access pulses one cycle, 1 cycle after byte 12; rx_packet=0x0C0B0A09080706050403020100; pkt_count=1.
REQ-040 Back-to-back: 2 packets in 26 consecutive frame-high bytes, rx_wait=0 -> two 1-cycle rx_access pulses 13 cycles apart; pkt_count=2; frame_err=0.
REQ-041 Frame dropped after byte 5 -> no rx_access; frame_err=1 -> a following full packet delivers correctly -> clr_status pulse -> frame_err=0.
REQ-042 rx_wait=1 held while 2 packets arrive (A then B) -> rx_access=1 with packet A stable; rxo_wr_wait=1; overflow=1 at B's completion; release -> A delivered, B lost, pkt_count=1.
REQ-043 Packet B completes on the same cycle packet A transfers -> rx_access stays high; B is presented next cycle; overflow=0.
REQ-044 Reset asserted at byte 7 then released; full packet sent -> no frame_err, exactly one correct delivery; pkt_count preset to 0xFFFF (by 65535 transfers or force) wraps to 0x0000 on the next transfer.
